seven_segment_scanner: RTL and testbench

Time-multiplexed driver for a 4-digit, common-anode seven-segment display. It sits directly downstream of the single-digit hex decode stage and owns the physical `seg`/`an`/`dp` pins. It takes a 16-bit value, snapshots it once per refresh frame so digits never tear, and cycles one anode at a time. A blanking gap at the start of each digit slot suppresses ghosting.

---
 rtl/seven_segment_scanner.sv | 173 +++++++++++++++++
 tb/tb_seven_segment_scanner.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: time-multiplexed driver for a 4-digit common-anode
// seven-segment display. A prescaler divides each digit slot into CLK_DIV
// cycles. The first BLANK_CYCLES cycles of every slot keep all anodes dark.
// The displayed value is snapshotted once per frame, so digits never tear.
//
// Optional feature: define LEADING_ZERO_BLANK_EN to suppress leading zero
// digits 3..1. Digit 0 is always shown. Decimal points stay driven.
//
// Handshake: none. value/dp_in are sampled, not handshaked. enable=0 freezes
// scanning and darkens the display. All outputs are registered and lag the
// internal pcnt/didx by one cycle.
module seven_segment_scanner #(
   parameter int CLK_DIV      = 100000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [15:0] value,
   input  logic [3:0]  dp_in,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  an,
   output logic        frame_done
);

   localparam int PW = $clog2(CLK_DIV);
   localparam logic [PW-1:0] PCNT_LAST  = PW'(CLK_DIV - 1);
   localparam logic [PW-1:0] PCNT_BLANK = PW'(BLANK_CYCLES);

`ifdef LEADING_ZERO_BLANK_EN
   localparam bit LZ_BLANK = 1'b1;
`else
   localparam bit LZ_BLANK = 1'b0;
`endif

   logic [PW-1:0] pcnt_q, pcnt_d;
   logic [1:0]    didx_q, didx_d;
   logic [15:0]   snap_val_q, snap_val_d;
   logic [3:0]    snap_dp_q, snap_dp_d;
   logic          first_q, first_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;
   logic [3:0]    an_q, an_d;
   logic          frame_done_q, frame_done_d;

   // Combinational helpers for the current slot.
   logic          tc;
   logic [15:0]   cur_val;
   logic [3:0]    cur_dp;
   logic [3:0]    nib;
   logic          suppress;

   // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0:    s = 7'b1000000;
         4'h1:    s = 7'b1111001;
         4'h2:    s = 7'b0100100;
         4'h3:    s = 7'b0110000;
         4'h4:    s = 7'b0011001;
         4'h5:    s = 7'b0010010;
         4'h6:    s = 7'b0000010;
         4'h7:    s = 7'b1111000;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0010000;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b0000011;
         4'hC:    s = 7'b1000110;
         4'hD:    s = 7'b0100001;
         4'hE:    s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   // Select the current digit and decide whether it is a suppressed leading zero.
   always_comb begin
      tc = (pcnt_q == PCNT_LAST);
      // On the first enabled cycle after reset the fresh snapshot is already
      // the one being displayed.
      cur_val = first_q ? value : snap_val_q;
      cur_dp  = first_q ? dp_in : snap_dp_q;
      nib      = 4'h0;
      suppress = 1'b0;
      case (didx_q)
         2'd0: begin
            nib      = cur_val[3:0];
            suppress = 1'b0;
         end
         2'd1: begin
            nib      = cur_val[7:4];
            suppress = LZ_BLANK && (cur_val[15:4] == 12'h000);
         end
         2'd2: begin
            nib      = cur_val[11:8];
            suppress = LZ_BLANK && (cur_val[15:8] == 8'h00);
         end
         default: begin
            nib      = cur_val[15:12];
            suppress = LZ_BLANK && (cur_val[15:12] == 4'h0);
         end
      endcase
   end

   // Next-state for the counters, the snapshot and the registered pin drivers.
   always_comb begin
      pcnt_d       = pcnt_q;
      didx_d       = didx_q;
      snap_val_d   = snap_val_q;
      snap_dp_d    = snap_dp_q;
      first_d      = first_q;
      an_d         = 4'b1111;
      seg_d        = 7'b1111111;
      dp_d         = 1'b1;
      frame_done_d = 1'b0;
      if (enable) begin
         first_d    = 1'b0;
         snap_val_d = cur_val;
         snap_dp_d  = cur_dp;
         if (tc) begin
            pcnt_d = '0;
            didx_d = didx_q + 2'd1;
            if (didx_q == 2'd3) begin
               snap_val_d   = value;
               snap_dp_d    = dp_in;
               frame_done_d = 1'b1;
            end
         end else begin
            pcnt_d = pcnt_q + 1'b1;
         end
         if ((pcnt_q < PCNT_BLANK) || suppress) begin
            an_d = 4'b1111;
         end else begin
            an_d = ~(4'b0001 << didx_q);
         end
         seg_d = suppress ? 7'b1111111 : hex_to_seg(nib);
         dp_d  = ~cur_dp[didx_q];
      end
   end

   // State and output registers, asynchronously cleared.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt_q       <= '0;
         didx_q       <= 2'd0;
         snap_val_q   <= 16'h0000;
         snap_dp_q    <= 4'h0;
         first_q      <= 1'b1;
         seg_q        <= 7'b1111111;
         dp_q         <= 1'b1;
         an_q         <= 4'b1111;
         frame_done_q <= 1'b0;
      end else begin
         pcnt_q       <= pcnt_d;
         didx_q       <= didx_d;
         snap_val_q   <= snap_val_d;
         snap_dp_q    <= snap_dp_d;
         first_q      <= first_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         an_q         <= an_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign seg        = seg_q;
   assign dp         = dp_q;
   assign an         = an_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb_seven_segment_scanner: drives the scanner with CLK_DIV=8, BLANK_CYCLES=2.
// Expected pin values come from a position-in-frame model: the number of
// enabled clock edges since reset determines the digit and slot offset.
module tb_seven_segment_scanner;

   localparam int CD    = 8;
   localparam int BL    = 2;
   localparam int FRAME = 4 * CD;

`ifdef LEADING_ZERO_BLANK_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [15:0] value;
   logic [3:0]  dp_in;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        frame_done;

   int checks = 0;
   int errors = 0;

   // Reference model state.
   logic [6:0]  seg_tab [16];
   int          m_n;
   logic [15:0] m_snap;
   logic [3:0]  m_sdp;
   logic [3:0]  exp_an;
   logic [6:0]  exp_seg;
   logic        exp_dp;
   logic        exp_fd;

   seven_segment_scanner #(
      .CLK_DIV      (CD),
      .BLANK_CYCLES (BL)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .value      (value),
      .dp_in      (dp_in),
      .seg        (seg),
      .dp         (dp),
      .an         (an),
      .frame_done (frame_done)
   );

   // Clock generation.
   always #5 clk = ~clk;

   task automatic model_reset();
      m_n     = 0;
      m_snap  = 16'h0000;
      m_sdp   = 4'h0;
      exp_an  = 4'hF;
      exp_seg = 7'h7F;
      exp_dp  = 1'b1;
      exp_fd  = 1'b0;
   endtask

   // Predict the pins after the coming rising edge from the current inputs.
   task automatic model_edge();
      int p, d, off;
      int nib;
      bit supp;
      if (!rst_n) begin
         model_reset();
      end else if (!enable) begin
         exp_an  = 4'hF;
         exp_seg = 7'h7F;
         exp_dp  = 1'b1;
         exp_fd  = 1'b0;
      end else begin
         if (m_n == 0) begin
            m_snap = value;
            m_sdp  = dp_in;
         end
         p    = m_n % FRAME;
         d    = p / CD;
         off  = p % CD;
         nib  = (int'(m_snap) / (16 ** d)) % 16;
         supp = LZB && (d != 0) && ((int'(m_snap) / (16 ** d)) == 0);
         exp_an  = (off < BL || supp) ? 4'hF : (4'hF ^ 4'(1 << d));
         exp_seg = supp ? 7'h7F : seg_tab[nib];
         exp_dp  = ~m_sdp[d];
         exp_fd  = 1'b0;
         if (p == FRAME - 1) begin
            m_snap = value;
            m_sdp  = dp_in;
            exp_fd = 1'b1;
         end
         m_n++;
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      enable = 1'b1;
      value  = 16'h1234;
      dp_in  = 4'h0;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_hold: got an=%b seg=%b dp=%b fd=%b, expected an=1111 seg=1111111 dp=1 fd=0",
                     an, seg, dp, frame_done);
         end
      end
      rst_n = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         tick();
         checks++;
         if ({an, seg, dp, frame_done} !== {exp_an, exp_seg, exp_dp, exp_fd}) begin
            errors++;
            $display("FAIL reset_scan c%0d: got an=%b seg=%b dp=%b fd=%b, expected an=%b seg=%b dp=%b fd=%b",
                     c, an, seg, dp, frame_done, exp_an, exp_seg, exp_dp, exp_fd);
         end
         if (c <= 2) begin
            checks++;
            if (an !== 4'b1111) begin
               errors++;
               $display("FAIL reset_blank c%0d: got an=%b, expected 1111", c, an);
            end
         end
         if (c == 3) begin
            checks++;
            if ({an, seg} !== {4'b1110, 7'b0011001}) begin
               errors++;
               $display("FAIL reset_first_lit: got an=%b seg=%b, expected an=1110 seg=0011001", an, seg);
            end
         end
         if (c == 11) begin
            checks++;
            if ({an, seg} !== {4'b1101, 7'b0110000}) begin
               errors++;
               $display("FAIL reset_digit1: got an=%b seg=%b, expected an=1101 seg=0110000", an, seg);
            end
         end
      end
   endtask

   task automatic test_tearing();
      int fd_cnt;
      fd_cnt = 0;
      for (int k = 0; k < 2 * FRAME && (m_n % FRAME) != CD; k++) begin
         tick();
         checks++;
         if ({an, seg, dp, frame_done} !== {exp_an, exp_seg, exp_dp, exp_fd}) begin
            errors++;
            $display("FAIL tear_sync: got an=%b seg=%b dp=%b fd=%b, expected an=%b seg=%b dp=%b fd=%b",
                     an, seg, dp, frame_done, exp_an, exp_seg, exp_dp, exp_fd);
         end
      end
      value = 16'hABCD;
      for (int c = 0; c < 30; c++) begin
         tick();
         checks++;
         if ({an, seg, dp, frame_done} !== {exp_an, exp_seg, exp_dp, exp_fd}) begin
            errors++;
            $display("FAIL tear_scan c%0d: got an=%b seg=%b dp=%b fd=%b, expected an=%b seg=%b dp=%b fd=%b",
                     c, an, seg, dp, frame_done, exp_an, exp_seg, exp_dp, exp_fd);
         end
         if (frame_done === 1'b1) fd_cnt++;
         if (fd_cnt == 0 && an === 4'b1011) begin
            checks++;
            if (seg !== 7'b0100100) begin
               errors++;
               $display("FAIL tear_digit2: got seg=%b, expected 0100100", seg);
            end
         end
         if (fd_cnt == 0 && an === 4'b0111) begin
            checks++;
            if (seg !== 7'b1111001) begin
               errors++;
               $display("FAIL tear_digit3: got seg=%b, expected 1111001", seg);
            end
         end
         if (fd_cnt == 1 && an === 4'b1110) begin
            checks++;
            if (seg !== 7'b0100001) begin
               errors++;
               $display("FAIL tear_new_digit0: got seg=%b, expected 0100001", seg);
            end
         end
      end
      checks++;
      if (fd_cnt != 1) begin
         errors++;
         $display("FAIL tear_frame_done: got %0d pulses, expected 1", fd_cnt);
      end
   endtask

   task automatic test_enable();
      for (int k = 0; k < CD && (m_n % CD) != 4; k++) begin
         tick();
         checks++;
         if ({an, seg, dp, frame_done} !== {exp_an, exp_seg, exp_dp, exp_fd}) begin
            errors++;
            $display("FAIL en_sync: got an=%b seg=%b dp=%b fd=%b, expected an=%b seg=%b dp=%b fd=%b",
                     an, seg, dp, frame_done, exp_an, exp_seg, exp_dp, exp_fd);
         end
      end
      enable = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++;
         if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL en_dark c%0d: got an=%b seg=%b dp=%b fd=%b, expected an=1111 seg=1111111 dp=1 fd=0",
                     c, an, seg, dp, frame_done);
         end
      end
      enable = 1'b1;
      for (int c = 0; c < 12; c++) begin
         tick();
         checks++;
         if ({an, seg, dp, frame_done} !== {exp_an, exp_seg, exp_dp, exp_fd}) begin
            errors++;
            $display("FAIL en_resume c%0d: got an=%b seg=%b dp=%b fd=%b, expected an=%b seg=%b dp=%b fd=%b",
                     c, an, seg, dp, frame_done, exp_an, exp_seg, exp_dp, exp_fd);
         end
      end
      // Drop enable exactly on a terminal count: the slot must not advance.
      for (int k = 0; k < CD && (m_n % CD) != CD - 1; k++) begin
         tick();
         checks++;
         if ({an, seg, dp, frame_done} !== {exp_an, exp_seg, exp_dp, exp_fd}) begin
            errors++;
            $display("FAIL en_tc_sync: got an=%b seg=%b dp=%b fd=%b, expected an=%b seg=%b dp=%b fd=%b",
                     an, seg, dp, frame_done, exp_an, exp_seg, exp_dp, exp_fd);
         end
      end
      enable = 1'b0;
      tick();
      enable = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         checks++;
         if ({an, seg, dp, frame_done} !== {exp_an, exp_seg, exp_dp, exp_fd}) begin
            errors++;
            $display("FAIL en_tc c%0d: got an=%b seg=%b dp=%b fd=%b, expected an=%b seg=%b dp=%b fd=%b",
                     c, an, seg, dp, frame_done, exp_an, exp_seg, exp_dp, exp_fd);
         end
      end
   endtask

   task automatic test_async_reset();
      for (int k = 0; k < 2 * FRAME && (m_n % FRAME) != 2 * CD + 5; k++) begin
         tick();
         checks++;
         if ({an, seg, dp, frame_done} !== {exp_an, exp_seg, exp_dp, exp_fd}) begin
            errors++;
            $display("FAIL arst_sync: got an=%b seg=%b dp=%b fd=%b, expected an=%b seg=%b dp=%b fd=%b",
                     an, seg, dp, frame_done, exp_an, exp_seg, exp_dp, exp_fd);
         end
      end
      checks++;
      if (an !== 4'b1011) begin
         errors++;
         $display("FAIL arst_digit2_lit: got an=%b, expected 1011", an);
      end
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL arst_immediate: got an=%b seg=%b dp=%b fd=%b, expected an=1111 seg=1111111 dp=1 fd=0",
                  an, seg, dp, frame_done);
      end
      #2;
      rst_n = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         tick();
         checks++;
         if ({an, seg, dp, frame_done} !== {exp_an, exp_seg, exp_dp, exp_fd}) begin
            errors++;
            $display("FAIL arst_restart c%0d: got an=%b seg=%b dp=%b fd=%b, expected an=%b seg=%b dp=%b fd=%b",
                     c, an, seg, dp, frame_done, exp_an, exp_seg, exp_dp, exp_fd);
         end
         if (c == BL + 1) begin
            checks++;
            if (an !== 4'b1110) begin
               errors++;
               $display("FAIL arst_first_digit: got an=%b, expected 1110", an);
            end
         end
      end
   endtask

   task automatic test_leading_zero();
      int d2_lit;
      int dp_low;
      d2_lit = 0;
      dp_low = 0;
      value  = 16'h0007;
      dp_in  = 4'b0100;
      rst_n  = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 40; c++) begin
         tick();
         checks++;
         if ({an, seg, dp, frame_done} !== {exp_an, exp_seg, exp_dp, exp_fd}) begin
            errors++;
            $display("FAIL lz_scan c%0d: got an=%b seg=%b dp=%b fd=%b, expected an=%b seg=%b dp=%b fd=%b",
                     c, an, seg, dp, frame_done, exp_an, exp_seg, exp_dp, exp_fd);
         end
         if (an === 4'b1011) d2_lit++;
         if (dp === 1'b0) dp_low++;
         if (an === 4'b1110) begin
            checks++;
            if (seg !== 7'b1111000) begin
               errors++;
               $display("FAIL lz_digit0: got seg=%b, expected 1111000", seg);
            end
         end
      end
      checks++;
      if (d2_lit != (LZB ? 0 : CD - BL)) begin
         errors++;
         $display("FAIL lz_digit2_lit: got %0d cycles, expected %0d", d2_lit, (LZB ? 0 : CD - BL));
      end
      checks++;
      if (dp_low != CD) begin
         errors++;
         $display("FAIL lz_dp_cycles: got %0d cycles, expected %0d", dp_low, CD);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(0, 19) == 0) value = 16'($urandom_range(0, 65535) >> (4 * $urandom_range(0, 4)));
         if ($urandom_range(0, 19) == 0) dp_in = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 15) == 0) enable = ~enable;
         if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
         tick();
         checks++;
         if ({an, seg, dp, frame_done} !== {exp_an, exp_seg, exp_dp, exp_fd}) begin
            errors++;
            $display("FAIL random c%0d: got an=%b seg=%b dp=%b fd=%b, expected an=%b seg=%b dp=%b fd=%b",
                     c, an, seg, dp, frame_done, exp_an, exp_seg, exp_dp, exp_fd);
         end
      end
   endtask

   initial begin
      seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
      seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
      seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
      seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
      seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
      seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
      seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001;
      seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;
      rst_n  = 1'b0;
      enable = 1'b0;
      value  = 16'h0000;
      dp_in  = 4'h0;
      model_reset();
      test_reset();
      test_tearing();
      test_enable();
      test_async_reset();
      test_leading_zero();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
